// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, widths and a small index helper
package uart_pkg;
  localparam int DW_DEF = 8;
  localparam int CNT_W = 16;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    BLANK = 2'd2,
    WAIT  = 2'd3
  } state_t;
  function automatic int wrap_add(input int a, input int b, input int n);
    return (a + b) % n;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: rotating-priority selector, first eligible index at or after ptr
module rr_pick import uart_pkg::*; #(
  parameter int NREQ = 4,
  parameter int PW = 2
) (
  input  logic [NREQ-1:0] eligible,
  input  logic [PW-1:0]   ptr,
  output logic            found,
  output logic [PW-1:0]   index
);
  // scanning from the far end lets the closest-to-ptr hit overwrite the rest
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (eligible[PW'(wrap_add(int'(ptr), k, NREQ))]) begin
        found = 1'b1;
        index = PW'(wrap_add(int'(ptr), k, NREQ));
      end
    end
  end
endmodule

// File: rtl/tx_arbiter.sv
// tx_arbiter: round-robin byte scheduler in front of the UART transmit engine,
// with per-requester lock to keep multi-byte messages contiguous
module tx_arbiter import uart_pkg::*; #(
  parameter int NREQ = 4,
  parameter int DW = DW_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DW-1:0]       wdata,
  input  logic [NREQ-1:0]          lock,
  output logic [NREQ-1:0]          ack,
  input  logic                     tx_ready,
  output logic                     load,
  output logic [DW-1:0]            tx_data,
  output logic [$clog2(NREQ)-1:0]  owner,
  output logic                     busy,
  output logic [CNT_W-1:0]         sent_cnt
);
  localparam int PW = $clog2(NREQ);
  state_t state, state_n;
  logic own_vld, found, grant;
  logic [PW-1:0] ptr, g;
  logic [NREQ-1:0] eligible;
  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .eligible(eligible),
    .ptr(ptr),
    .found(found),
    .index(g)
  );
  always_comb begin
    eligible = (own_vld && lock[owner]) ? (req & (NREQ'(1) << owner)) : req;
    grant = state == IDLE && tx_ready && found;
    state_n = grant ? LOAD :
              state == LOAD ? BLANK :
              state == BLANK ? WAIT :
              (state == WAIT && tx_ready) ? IDLE : state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      load <= 1'b0;
      ack <= '0;
      tx_data <= '0;
      owner <= '0;
      own_vld <= 1'b0;
      ptr <= '0;
      busy <= 1'b0;
      sent_cnt <= '0;
    end else begin
      state <= state_n;
      load <= grant;
      ack <= grant ? (NREQ'(1) << g) : '0;
      busy <= state_n != IDLE;
      if (grant) begin
        tx_data <= wdata[g*DW +: DW];
        owner <= g;
        own_vld <= lock[g];
        ptr <= (g == PW'(NREQ - 1)) ? '0 : g + 1'b1;
        sent_cnt <= sent_cnt + 1'b1;
      end else if (state == IDLE && !lock[owner]) begin
        own_vld <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_tx_arbiter.sv
// tb_tx_arbiter: directed and randomized checks of tx_arbiter against a
// transaction-level model (idle / cycles-since-grant, modulo round-robin search)
module tb_tx_arbiter;
  import uart_pkg::*;
  localparam int N = 4;
  localparam int DW = 8;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] lock = '0;
  logic [N-1:0] ack;
  logic [N*DW-1:0] wdata = '0;
  logic tx_ready = 1'b0;
  logic load, busy;
  logic [DW-1:0] tx_data;
  logic [1:0] owner;
  logic [15:0] sent_cnt;
  int n_chk = 0;
  int n_bad = 0;
  int eng_wait = 0;
  bit m_idle, m_ownvld;
  int m_age, m_ptr;
  logic e_load, e_busy;
  logic [N-1:0] e_ack;
  logic [DW-1:0] e_data;
  logic [1:0] e_owner;
  logic [15:0] e_cnt;

  always #5 clk = ~clk;

  tx_arbiter #(.NREQ(N), .DW(DW)) dut (
    .clk(clk), .rst(rst), .req(req), .wdata(wdata), .lock(lock), .ack(ack),
    .tx_ready(tx_ready), .load(load), .tx_data(tx_data), .owner(owner),
    .busy(busy), .sent_cnt(sent_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic mreset();
    m_idle = 1; m_ownvld = 0; m_age = 0; m_ptr = 0;
    e_load = 0; e_busy = 0; e_ack = '0; e_data = '0; e_owner = '0; e_cnt = '0;
  endtask

  // predicts outputs after the next rising edge from the inputs now applied
  task automatic mstep();
    logic [N-1:0] elig;
    int g;
    e_load = 0;
    e_ack = '0;
    if (m_idle) begin
      elig = (m_ownvld && lock[e_owner]) ? (req & (N'(1) << e_owner)) : req;
      if (!lock[e_owner]) m_ownvld = 0;
      g = -1;
      if (tx_ready)
        for (int k = 0; k < N; k++)
          if (g < 0 && elig[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      if (g >= 0) begin
        e_load = 1;
        e_ack = N'(1) << g;
        e_data = wdata[g*DW +: DW];
        e_owner = 2'(g);
        m_ownvld = lock[g];
        m_ptr = (g + 1) % N;
        e_cnt = e_cnt + 16'd1;
        m_idle = 0;
        m_age = 0;
      end
    end else if (m_age >= 2 && tx_ready) m_idle = 1;
    else m_age++;
    e_busy = !m_idle;
  endtask

  task automatic tick();
    mstep();
    @(negedge clk);
    chk("load", 32'(load), 32'(e_load));
    chk("ack", 32'(ack), 32'(e_ack));
    chk("tx_data", 32'(tx_data), 32'(e_data));
    chk("owner", 32'(owner), 32'(e_owner));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("sent_cnt", 32'(sent_cnt), 32'(e_cnt));
  endtask

  task automatic do_reset();
    req = '0; lock = '0; tx_ready = 1'b0; eng_wait = 0;
    rst = 1'b1;
    #1;
    mreset();
    rst = 1'b0;
    #1;
  endtask

  // engine model: drops ready when loaded, stays busy a random frame time
  task automatic eng(input bit jitter);
    if (load) begin
      tx_ready = 1'b0;
      eng_wait = $urandom_range(0, 5);
    end else if (eng_wait > 0) begin
      eng_wait--;
      tx_ready = 1'b0;
    end else tx_ready = jitter ? ($urandom_range(0, 7) != 0) : 1'b1;
  endtask

  initial begin
    int nloads, nb;
    int order[$];
    logic [7:0] q[$];
    logic [1:0] oq[$];
    int cnt[N];
    #2 rst = 1'b1;
    mreset();
    @(negedge clk);
    chk("rst_load", 32'(load), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cnt", 32'(sent_cnt), 0);
    chk("rst_owner", 32'(owner), 0);
    chk("rst_data", 32'(tx_data), 0);
    rst = 1'b0;
    // single requester
    req = 4'b0100; wdata[2*DW +: DW] = 8'h41; tx_ready = 1'b1;
    tick();
    chk("single_load", 32'(load), 1);
    chk("single_ack", 32'(ack), 4);
    chk("single_data", 32'(tx_data), 32'h41);
    chk("single_owner", 32'(owner), 2);
    chk("single_cnt", 32'(sent_cnt), 1);
    req = '0;
    repeat (4) tick();
    // reset during WAIT
    req = 4'b0001;
    tick();
    tx_ready = 1'b0;
    repeat (3) tick();
    chk("wait_busy", 32'(busy), 1);
    rst = 1'b1;
    #1;
    chk("arst_load", 32'(load), 0);
    chk("arst_ack", 32'(ack), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_cnt", 32'(sent_cnt), 0);
    chk("arst_owner", 32'(owner), 0);
    mreset();
    req = 4'b1000; tx_ready = 1'b1;
    #1 rst = 1'b0;
    tick();
    chk("post_rst_ack", 32'(ack), 8);
    req = 4'b1001;
    repeat (3) tick();
    tick();
    chk("post_rst_wrap_ack", 32'(ack), 1);
    req = '0;
    repeat (4) tick();
    // engine not ready for 50 cycles
    req = 4'b0001; tx_ready = 1'b0; nloads = 0;
    repeat (50) begin
      tick();
      if (load) nloads++;
    end
    chk("stall_loads", 32'(nloads), 0);
    chk("stall_busy", 32'(busy), 0);
    tx_ready = 1'b1;
    tick();
    chk("stall_release_load", 32'(load), 1);
    req = '0;
    repeat (4) tick();
    // all requesting: strict 0,1,2,3 rotation
    do_reset();
    req = 4'hF;
    for (int i = 0; i < N; i++) wdata[i*DW +: DW] = 8'($urandom);
    for (int c = 0; c < 400 && order.size() < 16; c++) begin
      eng(1'b0);
      tick();
      if (ack != '0) order.push_back($clog2(ack));
    end
    chk("order_count", 32'(order.size()), 16);
    for (int j = 0; j < 16 && j < order.size(); j++) begin
      chk("order_idx", 32'(order[j]), 32'(j % N));
      cnt[order[j]]++;
    end
    for (int i = 0; i < N; i++) chk("order_fair", 32'(cnt[i]), 4);
    // locked 3-byte message from requester 1
    do_reset();
    tx_ready = 1'b1; lock = 4'b0010; req = 4'b0010; nb = 0;
    wdata = {8'h33, 8'h22, 8'h10, 8'hA0};
    for (int c = 0; c < 80 && q.size() < 4; c++) begin
      tick();
      if (load) begin
        q.push_back(tx_data);
        oq.push_back(owner);
      end
      if (ack[1]) begin
        nb++;
        req[0] = 1'b1;
        req[3] = 1'b1;
        if (nb < 3) wdata[DW +: DW] = 8'(16 + nb);
        else begin
          req[1] = 1'b0;
          lock[1] = 1'b0;
        end
      end
    end
    chk("lock_count", 32'(q.size()), 4);
    if (q.size() == 4) begin
      chk("lock_b0", 32'(q[0]), 32'h10);
      chk("lock_b1", 32'(q[1]), 32'h11);
      chk("lock_b2", 32'(q[2]), 32'h12);
      chk("lock_next_owner", 32'(oq[3]), 3);
    end
    // counter wrap
    do_reset();
    force dut.sent_cnt = 16'hFFFF;
    #1 release dut.sent_cnt;
    e_cnt = 16'hFFFF;
    chk("wrap_preset", 32'(sent_cnt), 32'hFFFF);
    req = 4'b0001; tx_ready = 1'b1;
    tick();
    chk("wrap_load", 32'(load), 1);
    chk("wrap_zero", 32'(sent_cnt), 0);
    req = '0;
    repeat (4) tick();
    // randomized traffic with locks and withdrawals
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      eng(1'b1);
      for (int i = 0; i < N; i++) begin
        if (ack[i] || !req[i]) begin
          req[i] = ($urandom_range(0, 3) == 0);
          wdata[i*DW +: DW] = 8'($urandom);
        end else if ($urandom_range(0, 31) == 0) req[i] = 1'b0;
        if ($urandom_range(0, 15) == 0) lock[i] = ~lock[i];
      end
      tick();
    end
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
